// File: rtl/port_pkg.sv
// Shared width and transmit FSM state encoding for the port feeder.
package port_pkg;
    localparam int PORT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_GAP
    } tx_state_e;
endpackage

// File: rtl/port_fifo.sv
// Circular transmit buffer; pointers wrap modulo DEPTH, count tracks occupancy.
module port_fifo
    import port_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PORT_W-1:0]        wdata,
    input  logic                     pop,
    output logic [PORT_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PORT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/port_feeder.sv
// Host-side driver for the computer's I/O port: buffered strobed writes out,
// change-captured port_out bytes back to the host.
module port_feeder
    import port_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_valid,
    input  logic [PORT_W-1:0]      host_data,
    output logic                   host_ready,
    output logic                   port_write,
    output logic [PORT_W-1:0]      port_in,
    input  logic [PORT_W-1:0]      port_out,
    output logic                   obs_valid,
    output logic [PORT_W-1:0]      obs_data,
    input  logic                   obs_ready,
    output logic                   overrun,
    output logic [$clog2(DEPTH):0] count
);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic              fifo_full, fifo_empty, pop;
    logic [PORT_W-1:0] fifo_rdata;

    tx_state_e         state_q, state_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              port_write_q, port_write_d;
    logic [PORT_W-1:0] port_in_q, port_in_d;

    logic [PORT_W-1:0] prev_q;
    logic              obs_valid_q, obs_valid_d;
    logic [PORT_W-1:0] obs_data_q, obs_data_d;
    logic              overrun_q, overrun_d;

    assign host_ready = !fifo_full;

    port_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (host_valid && host_ready),
        .wdata (host_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The strobe is registered on the pop edge so port_in and port_write
    // move together and the strobe lasts exactly the STROBE cycle.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        port_write_d = 1'b0;
        port_in_d    = port_in_q;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    port_in_d    = fifo_rdata;
                    port_write_d = 1'b1;
                    state_d      = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GW'(GAP - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh capture takes priority over the host's consume on the same edge.
    always_comb begin
        obs_valid_d = obs_valid_q;
        obs_data_d  = obs_data_q;
        overrun_d   = overrun_q;
        if (port_out != prev_q) begin
            if (!obs_valid_q || obs_ready) begin
                obs_valid_d = 1'b1;
                obs_data_d  = port_out;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (obs_valid_q && obs_ready) begin
            obs_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            port_write_q <= 1'b0;
            port_in_q    <= '0;
            prev_q       <= '0;
            obs_valid_q  <= 1'b0;
            obs_data_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            port_write_q <= port_write_d;
            port_in_q    <= port_in_d;
            prev_q       <= port_out;
            obs_valid_q  <= obs_valid_d;
            obs_data_q   <= obs_data_d;
            overrun_q    <= overrun_d;
        end
    end

    assign port_write = port_write_q;
    assign port_in    = port_in_q;
    assign obs_valid  = obs_valid_q;
    assign obs_data   = obs_data_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_port_feeder.sv
// Directed bench for port_feeder (DEPTH=8, GAP=2): vector table plus
// hand-written burst/full and reset-mid-strobe sequences.
module tb_port_feeder;
    logic       clk = 1'b0;
    logic       reset;
    logic       host_valid;
    logic [7:0] host_data;
    logic       host_ready;
    logic       port_write;
    logic [7:0] port_in;
    logic [7:0] port_out;
    logic       obs_valid;
    logic [7:0] obs_data;
    logic       obs_ready;
    logic       overrun;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;

    port_feeder #(.DEPTH(8), .GAP(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .port_write (port_write),
        .port_in    (port_in),
        .port_out   (port_out),
        .obs_valid  (obs_valid),
        .obs_data   (obs_data),
        .obs_ready  (obs_ready),
        .overrun    (overrun),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hv;
        logic [7:0] hd;
        logic [7:0] po;
        logic       ordy;
        logic       hr;
        logic       pw;
        logic [7:0] pin;
        logic       ov;
        logic [7:0] od;
        logic       ovr;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    initial begin
        int  next, nstrobe, last_cyc, m;
        bit  acc, saw_full, saw_pp;

        //          hv  hd     po     rdy  hr  pw  pin    ov  od     ovr cnt
        tbl[0]  = '{1, 8'hA5, 8'h00, 0,   1,  0,  8'h00, 0,  8'h00, 0,  4'd1};
        tbl[1]  = '{0, 8'h00, 8'h00, 0,   1,  1,  8'hA5, 0,  8'h00, 0,  4'd0};
        tbl[2]  = '{0, 8'h00, 8'h00, 0,   1,  0,  8'hA5, 0,  8'h00, 0,  4'd0};
        tbl[3]  = '{0, 8'h00, 8'h00, 0,   1,  0,  8'hA5, 0,  8'h00, 0,  4'd0};
        tbl[4]  = '{0, 8'h00, 8'h00, 0,   1,  0,  8'hA5, 0,  8'h00, 0,  4'd0};
        tbl[5]  = '{0, 8'h00, 8'h3C, 0,   1,  0,  8'hA5, 1,  8'h3C, 0,  4'd0};
        tbl[6]  = '{0, 8'h00, 8'h77, 0,   1,  0,  8'hA5, 1,  8'h3C, 1,  4'd0};
        tbl[7]  = '{0, 8'h00, 8'h77, 1,   1,  0,  8'hA5, 0,  8'h3C, 1,  4'd0};
        tbl[8]  = '{0, 8'h00, 8'h77, 0,   1,  0,  8'hA5, 0,  8'h3C, 1,  4'd0};
        tbl[9]  = '{0, 8'h00, 8'h12, 1,   1,  0,  8'hA5, 1,  8'h12, 1,  4'd0};
        tbl[10] = '{0, 8'h00, 8'h12, 1,   1,  0,  8'hA5, 0,  8'h12, 1,  4'd0};
        tbl[11] = '{0, 8'h00, 8'h34, 1,   1,  0,  8'hA5, 1,  8'h34, 1,  4'd0};
        tbl[12] = '{0, 8'h00, 8'h56, 1,   1,  0,  8'hA5, 1,  8'h56, 1,  4'd0};
        tbl[13] = '{0, 8'h00, 8'h56, 0,   1,  0,  8'hA5, 1,  8'h56, 1,  4'd0};

        // Reset held with host_valid high: nothing may be accepted.
        reset      = 1'b0;
        host_valid = 1'b1;
        host_data  = 8'hA5;
        port_out   = 8'h00;
        obs_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_count", count, 0);
        end
        chk("rst_port_write", port_write, 0);
        chk("rst_port_in", port_in, 0);
        chk("rst_obs_valid", obs_valid, 0);
        chk("rst_obs_data", obs_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_host_ready", host_ready, 1);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            host_valid = tbl[i].hv;
            host_data  = tbl[i].hd;
            port_out   = tbl[i].po;
            obs_ready  = tbl[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_host_ready", i), host_ready, tbl[i].hr);
            chk($sformatf("v%0d_port_write", i), port_write, tbl[i].pw);
            chk($sformatf("v%0d_port_in", i), port_in, tbl[i].pin);
            chk($sformatf("v%0d_obs_valid", i), obs_valid, tbl[i].ov);
            chk($sformatf("v%0d_obs_data", i), obs_data, tbl[i].od);
            chk($sformatf("v%0d_overrun", i), overrun, tbl[i].ovr);
            chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
        end
        obs_ready = 1'b0;

        repeat (20) @(posedge clk);
        #1;
        chk("hold_port_in", port_in, 8'hA5);
        chk("hold_port_write", port_write, 0);

        // Burst of 14 bytes: fills the FIFO, then push and pop interleave.
        next = 1; nstrobe = 0; last_cyc = 0; m = 0; saw_full = 0; saw_pp = 0;
        for (int cyc = 0; cyc < 300 && nstrobe < 14; cyc++) begin
            host_valid = (next <= 14);
            host_data  = 8'(next);
            acc = host_valid && host_ready;
            @(posedge clk); #1;
            if (acc) next++;
            if (acc && port_write) saw_pp = 1;
            if (port_write) begin
                chk("burst_order", port_in, nstrobe + 1);
                if (nstrobe > 0) chk("burst_spacing", cyc - last_cyc, 4);
                last_cyc = cyc;
                nstrobe++;
            end
            m = m + int'(acc) - int'(port_write);
            chk("burst_count", count, m);
            chk("burst_ready", host_ready, (m != 8));
            if (m == 8) saw_full = 1;
        end
        host_valid = 1'b0;
        chk("burst_all_strobed", nstrobe, 14);
        chk("burst_reached_full", saw_full, 1);
        chk("burst_push_pop_same_edge", saw_pp, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("drain_no_strobe", port_write, 0);
            chk("drain_count", count, 0);
        end

        // Reset during STROBE with a second byte still queued.
        host_valid = 1'b1;
        host_data  = 8'h5A;
        @(posedge clk); #1;
        host_data = 8'h5B;
        @(posedge clk); #1;
        host_valid = 1'b0;
        chk("mid_strobe_pw", port_write, 1);
        chk("mid_strobe_pin", port_in, 8'h5A);
        chk("mid_strobe_count", count, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pw", port_write, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_pin", port_in, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_strobe", port_write, 0);
            chk("post_rst_count", count, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
